// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one cache fetch at a time, buffers {pc, word} toward decode.
// Optional perf counters are enabled with IFU_PERF_COUNTERS_EN.
module instruction_fetch_unit #(
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    output logic [31:0] cpu_addr,
    output logic        cpu_req,
    input  logic [31:0] cpu_data,
    input  logic        cpu_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
`ifdef IFU_PERF_COUNTERS_EN
    ,
    output logic [31:0] perf_fetch_count,
    output logic [31:0] perf_squash_count
`endif
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, SQUASH} state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     pend_pc_q, pend_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]     mem_pc_q   [FIFO_DEPTH];
    logic [31:0]     mem_data_q [FIFO_DEPTH];

    logic            push;
    logic            drop;
    logic            pop;
    logic            done;
    logic [31:0]     rpc;
    logic            unused_rpc_bits;

    assign rpc             = {redirect_pc[31:2], 2'b00};
    assign unused_rpc_bits = ^redirect_pc[1:0];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A redirect voids any pop in the same cycle because the whole buffer is flushed.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        push       = 1'b0;
        drop       = 1'b0;
        pop        = (count_q != '0) && instr_ready && !redirect_valid;
        done       = (state_q != IDLE) && cpu_ready;
        case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_d = rpc;
                    state_d    = RUN;
                end else if ((count_q - CW'(pop)) < CW'(FIFO_DEPTH)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (redirect_valid) begin
                    if (done) begin
                        drop       = 1'b1;
                        fetch_pc_d = rpc;
                    end else begin
                        pend_pc_d = rpc;
                        state_d   = SQUASH;
                    end
                end else if (done) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    if ((count_q + CW'(1) - CW'(pop)) == CW'(FIFO_DEPTH)) begin
                        state_d = IDLE;
                    end
                end
            end
            SQUASH: begin
                // The cache latched the old address; wait for it, then jump to the newest target.
                if (done) begin
                    drop       = 1'b1;
                    fetch_pc_d = redirect_valid ? rpc : pend_pc_q;
                    state_d    = RUN;
                end else if (redirect_valid) begin
                    pend_pc_d = rpc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        cpu_req     = (state_q != IDLE);
        cpu_addr    = fetch_pc_q;
        instr_valid = (count_q != '0);
        instr_pc    = mem_pc_q[rd_ptr_q];
        instr_data  = mem_data_q[rd_ptr_q];
    end

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (redirect_valid) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            count_d = count_q + CW'(push) - CW'(pop);
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            fetch_pc_q <= RESET_VECTOR;
            pend_pc_q  <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_pc_q[i]   <= '0;
                mem_data_q[i] <= '0;
            end
        end else if (push) begin
            mem_pc_q[wr_ptr_q]   <= fetch_pc_q;
            mem_data_q[wr_ptr_q] <= cpu_data;
        end
    end

`ifdef IFU_PERF_COUNTERS_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_squash_q, perf_squash_d;

    always_comb begin
        perf_fetch_d  = perf_fetch_q + {31'd0, push};
        perf_squash_d = perf_squash_q + {31'd0, drop};
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            perf_fetch_q  <= '0;
            perf_squash_q <= '0;
        end else begin
            perf_fetch_q  <= perf_fetch_d;
            perf_squash_q <= perf_squash_d;
        end
    end

    assign perf_fetch_count  = perf_fetch_q;
    assign perf_squash_count = perf_squash_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: cache model with configurable latency, reference model and scoreboard of buffered words.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RV    = 32'h0000_0100;
    localparam int          DEPTH = 4;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] cpu_addr;
    logic        cpu_req;
    logic [31:0] cpu_data;
    logic        cpu_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_ready;
`ifdef IFU_PERF_COUNTERS_EN
    logic [31:0] perf_fetch_count;
    logic [31:0] perf_squash_count;
`endif

    always #5 HCLK = ~HCLK;

    instruction_fetch_unit #(.FIFO_DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
        .HCLK(HCLK),
        .HRESETn(HRESETn),
        .cpu_addr(cpu_addr),
        .cpu_req(cpu_req),
        .cpu_data(cpu_data),
        .cpu_ready(cpu_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr_data(instr_data),
        .instr_pc(instr_pc),
        .instr_ready(instr_ready)
`ifdef IFU_PERF_COUNTERS_EN
        ,
        .perf_fetch_count(perf_fetch_count),
        .perf_squash_count(perf_squash_count)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        int          lat;
        int          pre;
        logic [31:0] rpc;
        logic [31:0] exp_addr;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    int          lat = 1;
    int          age = 0;
    logic [31:0] exp_pc;
    logic [31:0] m_pend;
    logic        m_req;
    logic        m_sq;
    int unsigned m_fetch;
    int unsigned m_drop;
    ent_t        sb[$];
    vec_t        vec[6];

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_0F96;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_pc  = RV;
        m_pend  = '0;
        m_req   = 1'b0;
        m_sq    = 1'b0;
        m_fetch = 0;
        m_drop  = 0;
        age     = 0;
        sb.delete();
    endtask

    // One clock cycle: drive cache response, check outputs mid-cycle, advance model across the edge.
    task automatic cyc();
        logic        done;
        logic        pop;
        logic        rv;
        logic        req_pre;
        logic [31:0] rpc;
        ent_t        e;
        cpu_ready = cpu_req && (age >= lat);
        cpu_data  = data_of(cpu_addr);
        #4;
        chk("cpu_req", {31'd0, cpu_req}, {31'd0, m_req});
        if (m_req) chk("cpu_addr", cpu_addr, exp_pc);
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, (sb.size() != 0)});
        if (sb.size() != 0) begin
            chk("instr_pc", instr_pc, sb[0].pc);
            chk("instr_data", instr_data, sb[0].data);
        end
`ifdef IFU_PERF_COUNTERS_EN
        chk("perf_fetch", perf_fetch_count, m_fetch);
        chk("perf_squash", perf_squash_count, m_drop);
`endif
        req_pre = cpu_req;
        done    = m_req && cpu_ready;
        rv      = redirect_valid;
        rpc     = {redirect_pc[31:2], 2'b00};
        pop     = (sb.size() != 0) && instr_ready && !rv;
        if (rv) begin
            sb.delete();
            if (done) m_drop++;
            if (!m_req) begin
                exp_pc = rpc;
                m_req  = 1'b1;
            end else if (done) begin
                exp_pc = rpc;
                m_sq   = 1'b0;
            end else begin
                m_pend = rpc;
                m_sq   = 1'b1;
            end
        end else begin
            if (pop) void'(sb.pop_front());
            if (!m_req) begin
                if (sb.size() < DEPTH) m_req = 1'b1;
            end else if (m_sq) begin
                if (done) begin
                    exp_pc = m_pend;
                    m_sq   = 1'b0;
                    m_drop++;
                end
            end else if (done) begin
                e.pc   = exp_pc;
                e.data = data_of(exp_pc);
                sb.push_back(e);
                exp_pc = exp_pc + 32'd4;
                m_fetch++;
                if (sb.size() == DEPTH) m_req = 1'b0;
            end
        end
        @(posedge HCLK);
        #1;
        if (req_pre && cpu_ready) age = 0;
        else if (req_pre) age++;
        redirect_valid = 1'b0;
    endtask

    task automatic do_reset();
        HRESETn        = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk("rst_req_now", {31'd0, cpu_req}, 32'd0);
        chk("rst_valid_now", {31'd0, instr_valid}, 32'd0);
        model_reset();
        @(posedge HCLK);
        #1;
        chk("rst_addr", cpu_addr, RV);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_instr_data", instr_data, 32'd0);
        HRESETn = 1'b1;
    endtask

    initial begin
        logic found;
        vec[0] = '{lat: 1, pre: 0, rpc: 32'h0000_0040, exp_addr: 32'h0000_0040};
        vec[1] = '{lat: 1, pre: 2, rpc: 32'h0000_2003, exp_addr: 32'h0000_2000};
        vec[2] = '{lat: 1, pre: 3, rpc: 32'h0000_2000, exp_addr: 32'h0000_2000};
        vec[3] = '{lat: 3, pre: 2, rpc: 32'hFFFF_FFFE, exp_addr: 32'hFFFF_FFFC};
        vec[4] = '{lat: 2, pre: 7, rpc: 32'h0000_0008, exp_addr: 32'h0000_0008};
        vec[5] = '{lat: 0, pre: 4, rpc: 32'h0000_1235, exp_addr: 32'h0000_1234};

        HRESETn        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b1;
        cpu_ready      = 1'b0;
        cpu_data       = '0;
        model_reset();

        // Streaming hits: one word per two cycles from the reset vector.
        do_reset();
        lat = 1;
        instr_ready = 1'b1;
        repeat (7) cyc();
        chk("stream_addr_c7", cpu_addr, RV + 32'h0C);

        // Decode stalled: buffer fills, fetch stops, one pop restarts it.
        do_reset();
        lat = 1;
        instr_ready = 1'b0;
        repeat (12) cyc();
        chk("full_req", {31'd0, cpu_req}, 32'd0);
        chk("full_head_pc", instr_pc, RV);
        instr_ready = 1'b1;
        cyc();
        instr_ready = 1'b0;
        chk("refill_req", {31'd0, cpu_req}, 32'd1);
        chk("refill_addr", cpu_addr, RV + 32'h10);

        // Redirect during a slow fetch: address holds, word discarded.
        do_reset();
        lat = 1;
        instr_ready = 1'b1;
        repeat (5) cyc();
        chk("sq_addr_pre", cpu_addr, 32'h108);
        lat = 4;
        redirect_valid = 1'b1;
        redirect_pc = 32'h2000;
        cyc();
        for (int k = 0; k < 3; k++) begin
            chk("sq_addr_hold", cpu_addr, 32'h108);
            chk("sq_valid_low", {31'd0, instr_valid}, 32'd0);
            cyc();
        end
        cyc();
        lat = 1;
        chk("sq_next_addr", cpu_addr, 32'h2000);
        chk("sq_valid_after", {31'd0, instr_valid}, 32'd0);

        // Two redirects during one squash: the latest wins.
        do_reset();
        lat = 1;
        repeat (5) cyc();
        lat = 4;
        redirect_valid = 1'b1;
        redirect_pc = 32'h3000;
        cyc();
        cyc();
        redirect_valid = 1'b1;
        redirect_pc = 32'h4000;
        cyc();
        cyc();
        cyc();
        lat = 1;
        chk("sq2_next_addr", cpu_addr, 32'h4000);

        // Redirect coincident with completion and a pop, buffer about to fill.
        do_reset();
        lat = 1;
        instr_ready = 1'b0;
        repeat (8) cyc();
        chk("coin_pre_addr", cpu_addr, 32'h10C);
        redirect_valid = 1'b1;
        redirect_pc = 32'h7000;
        instr_ready = 1'b1;
        cyc();
        instr_ready = 1'b0;
        chk("coin_valid", {31'd0, instr_valid}, 32'd0);
        chk("coin_addr", cpu_addr, 32'h7000);
`ifdef IFU_PERF_COUNTERS_EN
        chk("coin_perf_squash", perf_squash_count, 32'd1);
`endif
        repeat (4) cyc();

        // Reset in the middle of a miss with two words buffered.
        do_reset();
        lat = 1;
        instr_ready = 1'b0;
        repeat (5) cyc();
        lat = 10;
        cyc();
        cyc();
        chk("mid_valid", {31'd0, instr_valid}, 32'd1);
        do_reset();
        lat = 1;
        cyc();
        cyc();
        chk("restart_addr", cpu_addr, RV);

        // Redirect vectors: each from a fresh reset.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            lat = vec[i].lat;
            instr_ready = 1'b1;
            repeat (vec[i].pre) cyc();
            redirect_valid = 1'b1;
            redirect_pc = vec[i].rpc;
            cyc();
            found = 1'b0;
            for (int k = 0; k < 20 && !found; k++) begin
                if (cpu_req && !m_sq) begin
                    found = 1'b1;
                    chk("vec_first_addr", cpu_addr, vec[i].exp_addr);
                end else begin
                    cyc();
                end
            end
            if (!found) chk("vec_timeout", 32'd0, 32'd1);
            repeat (10) cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
